// File: rtl/audio_mix_sd_dac.sv
// audio_mix_sd_dac: volume/mute mixer over CHANNELS inputs (one shared multiplier) with
// saturated signed PCM output plus a 1st/2nd-order sigma-delta bitstream for the audio pins.
// Latency: pcm_valid CHANNELS+2 cycles after ce_sample; no backpressure, a busy ce_sample is dropped and flagged by overrun.
module audio_mix_sd_dac #(
  parameter int CHANNELS  = 2,
  parameter int IN_W      = 10,
  parameter int VOL_W     = 4,
  parameter int OUT_W     = 16,
  parameter int SIGNED_IN = 0,
  parameter int ORDER     = 1
) (
  input  logic                      clk_sys,
  input  logic                      reset,
  input  logic                      ce_sample,
  input  logic [CHANNELS*IN_W-1:0]  ch_in,
  input  logic [CHANNELS*VOL_W-1:0] ch_vol,
  input  logic [CHANNELS-1:0]       ch_mute,
  output logic [OUT_W-1:0]          pcm_out,
  output logic                      pcm_valid,
  output logic                      clip,
  output logic                      overrun,
  output logic                      dac_o
);

  localparam int IDX_W  = $clog2(CHANNELS + 1);
  localparam int PROD_W = IN_W + VOL_W + 1;
  localparam int ACC_W  = IN_W + VOL_W + 1 + $clog2(CHANNELS);
  localparam int SHIFT  = OUT_W - IN_W - VOL_W;
  localparam int SH_W   = ACC_W + SHIFT;

  typedef enum logic [1:0] {S_IDLE, S_LATCH, S_MAC, S_SAT} state_t;

  state_t                    state_q, state_d;
  logic [CHANNELS*IN_W-1:0]  in_q, in_d;
  logic [CHANNELS*VOL_W-1:0] vol_q, vol_d;
  logic [CHANNELS-1:0]       mute_q, mute_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic signed [PROD_W-1:0]  prod_q, prod_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [OUT_W-1:0]          pcm_q, pcm_d;
  logic                      valid_q, valid_d;
  logic                      clip_q, clip_d;
  logic                      ovr_q, ovr_d;
  logic                      dac_q, dac_d;

  // Datapath signals
  logic [IDX_W-1:0]          mul_idx;
  logic [IN_W-1:0]           mul_raw;
  logic [VOL_W-1:0]          mul_vol;
  logic                      mul_mute;
  logic signed [IN_W-1:0]    mul_s;
  logic signed [VOL_W:0]     mul_v;
  logic signed [ACC_W-1:0]   acc_sum;
  logic signed [SH_W-1:0]    shifted;
  logic [SH_W-OUT_W:0]       sh_top;
  logic                      sat_hit;
  logic [OUT_W-1:0]          sat_val;
  logic [OUT_W-1:0]          u;

  // Shared multiplier: product is registered one cycle ahead of its accumulation,
  // so LATCH loads channel 0 and each MAC cycle loads the next channel.
  always_comb begin
    mul_idx  = (state_q == S_LATCH) ? '0 : idx_q + 1'b1;
    mul_raw  = '0;
    mul_vol  = '0;
    mul_mute = 1'b1;
    for (int k = 0; k < CHANNELS; k++) begin
      if (mul_idx == IDX_W'(k)) begin
        mul_raw  = in_q[k*IN_W +: IN_W];
        mul_vol  = vol_q[k*VOL_W +: VOL_W];
        mul_mute = mute_q[k];
      end
    end
    // Offset-binary to two's complement is an MSB flip.
    mul_s   = (SIGNED_IN != 0) ? mul_raw : {~mul_raw[IN_W-1], mul_raw[IN_W-2:0]};
    mul_v   = mul_mute ? '0 : {1'b0, mul_vol};
    prod_d  = PROD_W'(mul_s) * PROD_W'(mul_v);
    acc_sum = acc_q + ACC_W'(prod_q);
    // Align to the PCM word, then clamp if the bits above the sign disagree.
    shifted = SH_W'(acc_sum) <<< SHIFT;
    sh_top  = shifted[SH_W-1:OUT_W-1];
    sat_hit = !((&sh_top) || !(|sh_top));
    if (!sat_hit)
      sat_val = shifted[OUT_W-1:0];
    else if (shifted[SH_W-1])
      sat_val = {1'b1, {(OUT_W-1){1'b0}}};
    else
      sat_val = {1'b0, {(OUT_W-1){1'b1}}};
  end

  // Mix sequencer: next state, input latch, accumulator and PCM result
  always_comb begin
    state_d = state_q;
    in_d    = in_q;
    vol_d   = vol_q;
    mute_d  = mute_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    pcm_d   = pcm_q;
    valid_d = 1'b0;
    clip_d  = 1'b0;
    ovr_d   = ce_sample && (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (ce_sample) begin
          in_d    = ch_in;
          vol_d   = ch_vol;
          mute_d  = ch_mute;
          acc_d   = '0;
          idx_d   = '0;
          state_d = S_LATCH;
        end
      end
      S_LATCH: state_d = S_MAC;
      S_MAC: begin
        acc_d = acc_sum;
        idx_d = idx_q + 1'b1;
        if (idx_q == IDX_W'(CHANNELS - 1)) begin
          pcm_d   = sat_val;
          valid_d = 1'b1;
          clip_d  = sat_hit;
          state_d = S_SAT;
        end
      end
      S_SAT:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Mixer state registers
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      in_q    <= '0;
      vol_q   <= '0;
      mute_q  <= '0;
      idx_q   <= '0;
      prod_q  <= '0;
      acc_q   <= '0;
      pcm_q   <= '0;
      valid_q <= 1'b0;
      clip_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      in_q    <= in_d;
      vol_q   <= vol_d;
      mute_q  <= mute_d;
      idx_q   <= idx_d;
      prod_q  <= prod_d;
      acc_q   <= acc_d;
      pcm_q   <= pcm_d;
      valid_q <= valid_d;
      clip_q  <= clip_d;
      ovr_q   <= ovr_d;
    end
  end

  // Modulator input: signed PCM re-offset to unsigned.
  assign u = {~pcm_q[OUT_W-1], pcm_q[OUT_W-2:0]};

  generate
    if (ORDER == 2) begin : g_sd2
      logic signed [OUT_W+3:0] i1_q, i1_d, i2_q, i2_d, u_ext, fb_ext;

      // Two cascaded integrators, both fed back from the previous output bit
      always_comb begin
        u_ext  = {4'b0000, u};
        fb_ext = dac_q ? {4'b0000, {OUT_W{1'b1}}} : '0;
        i1_d   = i1_q + u_ext - fb_ext;
        i2_d   = i2_q + i1_d - fb_ext;
        dac_d  = ~i2_d[OUT_W+3];
      end

      // Integrator registers
      always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
          i1_q <= '0;
          i2_q <= '0;
        end else begin
          i1_q <= i1_d;
          i2_q <= i2_d;
        end
      end
    end else begin : g_sd1
      logic [OUT_W-1:0] acc1_q;
      logic [OUT_W:0]   acc1_d;

      // Phase accumulator; its carry out is the bitstream
      always_comb begin
        acc1_d = {1'b0, acc1_q} + {1'b0, u};
        dac_d  = acc1_d[OUT_W];
      end

      // Accumulator register (carry lives in dac_q)
      always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) acc1_q <= '0;
        else       acc1_q <= acc1_d[OUT_W-1:0];
      end
    end
  endgenerate

  // Bitstream output register
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) dac_q <= 1'b0;
    else       dac_q <= dac_d;
  end

  assign pcm_out   = pcm_q;
  assign pcm_valid = valid_q;
  assign clip      = clip_q;
  assign overrun   = ovr_q;
  assign dac_o     = dac_q;

endmodule

// File: tb/tb_audio_mix_sd_dac.sv
// Bench for audio_mix_sd_dac: scoreboarded mixes (directed + random) on a first-order
// instance, bitstream density checks on first- and second-order instances.
module tb_audio_mix_sd_dac;
  localparam int CH    = 2;
  localparam int IN_W  = 10;
  localparam int VOL_W = 4;
  localparam int OUT_W = 16;
  localparam int LAT   = CH + 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   reset;
  logic                   ce, ce2;
  logic [CH*IN_W-1:0]     ch_in, ch_in2;
  logic [CH*VOL_W-1:0]    ch_vol, ch_vol2;
  logic [CH-1:0]          ch_mute, ch_mute2;
  logic [OUT_W-1:0]       pcm_out, pcm_out2;
  logic                   pcm_valid, clip, overrun, dac_o;
  logic                   pcm_valid2, clip2, overrun2, dac_o2;

  audio_mix_sd_dac #(.CHANNELS(CH), .IN_W(IN_W), .VOL_W(VOL_W), .OUT_W(OUT_W),
                     .SIGNED_IN(0), .ORDER(1)) dut (
    .clk_sys(clk), .reset(reset), .ce_sample(ce), .ch_in(ch_in), .ch_vol(ch_vol),
    .ch_mute(ch_mute), .pcm_out(pcm_out), .pcm_valid(pcm_valid), .clip(clip),
    .overrun(overrun), .dac_o(dac_o));

  audio_mix_sd_dac #(.CHANNELS(CH), .IN_W(IN_W), .VOL_W(VOL_W), .OUT_W(OUT_W),
                     .SIGNED_IN(0), .ORDER(2)) dut2 (
    .clk_sys(clk), .reset(reset), .ce_sample(ce2), .ch_in(ch_in2), .ch_vol(ch_vol2),
    .ch_mute(ch_mute2), .pcm_out(pcm_out2), .pcm_valid(pcm_valid2), .clip(clip2),
    .overrun(overrun2), .dac_o(dac_o2));

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int               at;
    logic [OUT_W-1:0] pcm;
    logic             clp;
  } exp_t;

  exp_t exp_q[$];
  int   ovr_q[$];
  int   busy_until = -1;

  task automatic check(input string name, input longint act, input longint exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic check_near(input string name, input longint act, input longint exp, input longint tol);
    compared++;
    if (act > exp + tol || act < exp - tol) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d +/- %0d", name, act, exp, tol);
    end
  endtask

  // Reference mix: offset-binary sample minus midscale, times volume (0 if muted),
  // summed, scaled up to the PCM word and clamped.
  function automatic void model_mix(input logic [CH*IN_W-1:0] ins, input logic [CH*VOL_W-1:0] vols,
                                    input logic [CH-1:0] mutes,
                                    output logic [OUT_W-1:0] pcm, output logic clp);
    longint sum, s, v, scaled, maxv, minv;
    sum = 0;
    for (int k = 0; k < CH; k++) begin
      s = longint'(ins[k*IN_W +: IN_W]) - (longint'(1) << (IN_W - 1));
      v = mutes[k] ? 0 : longint'(vols[k*VOL_W +: VOL_W]);
      sum += s * v;
    end
    scaled = sum * (longint'(1) << (OUT_W - IN_W - VOL_W));
    maxv = (longint'(1) << (OUT_W - 1)) - 1;
    minv = -(longint'(1) << (OUT_W - 1));
    clp = 1'b0;
    if (scaled > maxv) begin
      scaled = maxv;
      clp = 1'b1;
    end else if (scaled < minv) begin
      scaled = minv;
      clp = 1'b1;
    end
    pcm = scaled[OUT_W-1:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one ce_sample cycle and record what the mixer should do with it.
  task automatic pulse_ce(input logic [CH*IN_W-1:0] i, input logic [CH*VOL_W-1:0] v,
                          input logic [CH-1:0] m);
    logic [OUT_W-1:0] p;
    logic             c;
    ch_in = i; ch_vol = v; ch_mute = m; ce = 1'b1;
    if (cyc > busy_until) begin
      model_mix(i, v, m, p, c);
      exp_q.push_back('{at: cyc + LAT, pcm: p, clp: c});
      busy_until = cyc + LAT;
    end else begin
      ovr_q.push_back(cyc + 1);
    end
    step();
    ce = 1'b0;
  endtask

  task automatic rand_inputs();
    for (int k = 0; k < CH; k++) begin
      ch_in[k*IN_W +: IN_W]    = IN_W'($urandom_range(0, (1 << IN_W) - 1));
      ch_vol[k*VOL_W +: VOL_W] = VOL_W'($urandom_range(0, (1 << VOL_W) - 1));
      ch_mute[k]               = ($urandom_range(0, 4) == 0);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || ovr_q.size() != 0) && n < 40) begin
      step();
      n++;
    end
    if (exp_q.size() != 0 || ovr_q.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain: %0d results and %0d overruns still outstanding", exp_q.size(), ovr_q.size());
      exp_q.delete();
      ovr_q.delete();
    end
    step();
  endtask

  // Monitor: compares every presented result and overrun against the scoreboard.
  initial begin : monitor
    logic [OUT_W-1:0] last_pcm;
    logic             exp_ovr;
    exp_t             e;
    last_pcm = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        check("rst_pcm_out", pcm_out, 0);
        check("rst_pcm_valid", pcm_valid, 0);
        check("rst_clip", clip, 0);
        check("rst_overrun", overrun, 0);
        check("rst_dac_o", dac_o, 0);
        check("rst_dac_o2", dac_o2, 0);
        last_pcm = '0;
      end else begin
        exp_ovr = (ovr_q.size() != 0 && ovr_q[0] == cyc);
        if (exp_ovr) void'(ovr_q.pop_front());
        check("overrun", overrun, exp_ovr);
        if (pcm_valid) begin
          if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_pcm_valid @cyc %0d: got pcm_valid=1 expected 0", cyc);
          end else begin
            e = exp_q.pop_front();
            check("valid_cycle", cyc, e.at);
            check("pcm_out", pcm_out, e.pcm);
            check("clip", clip, e.clp);
            last_pcm = e.pcm;
          end
        end else begin
          check("clip_idle", clip, 0);
          check("pcm_hold", pcm_out, last_pcm);
          if (exp_q.size() != 0 && exp_q[0].at < cyc) begin
            compared++;
            mismatched++;
            $display("FAIL missing_pcm_valid: got none by cyc %0d expected at cyc %0d", cyc, exp_q[0].at);
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got no end of test, expected completion within time budget");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    longint u, cnt, k;
    logic [OUT_W-1:0] p2;
    logic             c2;
    bit               seen;
    reset = 1'b1; ce = 1'b0; ce2 = 1'b0;
    ch_in = '0; ch_vol = '0; ch_mute = '0;
    ch_in2 = '0; ch_vol2 = '0; ch_mute2 = '0;
    repeat (3) step();
    reset = 1'b0;

    // Idle bitstream at midscale: first-order output alternates 0,1,0,1...
    u = longint'(1) << (OUT_W - 1);
    for (k = 1; k <= 16; k++) begin
      step();
      check("dac_idle_alt", dac_o, ((k * u) >> OUT_W) - (((k - 1) * u) >> OUT_W));
    end

    // Single full-scale channel, other muted.
    pulse_ce({10'd0, 10'd1023}, {4'd15, 4'd15}, 2'b10);
    drain();
    check("single_ch_pcm_const", pcm_out, 16'h77C4);

    // First-order density with the mix held.
    u = longint'(pcm_out ^ (1 << (OUT_W - 1)));
    cnt = 0;
    repeat (4096) begin
      step();
      cnt += dac_o;
    end
    check_near("dac1_density", cnt, (4096 * u) >> OUT_W, 2);

    // Saturation both ways.
    pulse_ce({10'd1023, 10'd1023}, {4'd15, 4'd15}, 2'b00);
    drain();
    check("sat_pos_const", pcm_out, 16'h7FFF);
    pulse_ce({10'd0, 10'd0}, {4'd15, 4'd15}, 2'b00);
    drain();
    check("sat_neg_const", pcm_out, 16'h8000);

    // Second strobe two cycles later is dropped.
    pulse_ce({10'd700, 10'd300}, {4'd9, 4'd5}, 2'b00);
    step();
    pulse_ce({10'd100, 10'd900}, {4'd3, 4'd12}, 2'b00);
    drain();

    // Reset in the middle of a mix aborts it.
    pulse_ce({10'd800, 10'd200}, {4'd7, 4'd11}, 2'b00);
    step();
    reset = 1'b1;
    exp_q.delete();
    ovr_q.delete();
    busy_until = -1;
    step();
    step();
    reset = 1'b0;
    step();
    pulse_ce({10'd600, 10'd650}, {4'd10, 4'd6}, 2'b01);
    drain();

    // Random traffic; inputs churn every cycle to show they are only taken on accepted strobes.
    for (int n = 0; n < 300; n++) begin
      rand_inputs();
      if ($urandom_range(0, 3) == 0) pulse_ce(ch_in, ch_vol, ch_mute);
      else step();
    end
    drain();

    // Second-order instance: hold 0x4000 and measure ones density.
    ch_in2 = {10'd768, 10'd768}; ch_vol2 = {4'd8, 4'd8}; ch_mute2 = 2'b00;
    model_mix(ch_in2, ch_vol2, ch_mute2, p2, c2);
    ce2 = 1'b1;
    k = cyc;
    step();
    ce2 = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      if (pcm_valid2) seen = 1'b1;
      else step();
    end
    check("o2_valid_seen", seen, 1);
    check("o2_valid_cycle", cyc, k + LAT);
    check("o2_pcm_out", pcm_out2, p2);
    check("o2_pcm_const", pcm_out2, 16'h4000);
    check("o2_clip", clip2, c2);
    check("o2_overrun", overrun2, 0);
    u = longint'(p2 ^ (1 << (OUT_W - 1)));
    cnt = 0;
    repeat (4096) begin
      step();
      cnt += dac_o2;
    end
    check_near("dac2_density", cnt, (4096 * u) >> OUT_W, 4);

    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
